// File: rtl/alu_result_monitor.sv
// alu_result_monitor: response-side checker for the 16-bit structural ALU.
// Compares reference and DUT result sets {w, zero, neg}, checks that the
// reference flags agree with w_ref, counts operations and mismatches, keeps
// the first failure and buffers mismatching entries in a show-ahead FIFO.
// Optional build macro: MON_HALT_ON_ERR_EN (halt the run on the first mismatch).
//
// Handshake: in_valid qualifies in_func and both result sets for exactly the
// cycle it is high; there is no back-pressure, every valid cycle in RUN is
// accepted. rd_en pops the head entry when rd_empty=0 and is ignored otherwise;
// rd_data shows the head entry combinationally from storage (0 when empty).
module alu_result_monitor #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [2:0]         in_func,
  input  logic [WIDTH-1:0]   w_ref,
  input  logic               zero_ref,
  input  logic               neg_ref,
  input  logic [WIDTH-1:0]   w_dut,
  input  logic               zero_dut,
  input  logic               neg_dut,
  input  logic               rd_en,
  output logic [WIDTH+4:0]   rd_data,
  output logic               rd_empty,
  output logic               fifo_full,
  output logic               overflow,
  output logic               consist_err,
  output logic [CNT_W-1:0]   op_cnt,
  output logic [CNT_W-1:0]   mis_cnt,
  output logic               first_err_valid,
  output logic [2:0]         first_err_func,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic [1:0]         state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = WIDTH + 5;
  localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
  logic               first_err_valid_q, first_err_valid_d;
  logic [2:0]         first_err_func_q, first_err_func_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               overflow_q, overflow_d;
  logic               consist_err_q, consist_err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     occ_q, occ_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic               clear;
  logic               accept;
  logic               mismatch;
  logic               inconsist;
  logic               fifo_empty;
  logic               fifo_full_w;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               mem_we;
  logic [ENT_W-1:0]   mem_wdata;

  // Decode of this cycle's events: clear, accepted op, FIFO push/pop.
  always_comb begin
    // start clears in every state, except that stop wins over start in RUN.
    clear       = start && !((state_q == ST_RUN) && stop);
    // A restart cycle's in_valid is not counted.
    accept      = (state_q == ST_RUN) && in_valid && !clear;
    mismatch    = ({w_ref, zero_ref, neg_ref} != {w_dut, zero_dut, neg_dut});
    inconsist   = (zero_ref != (w_ref == '0)) || (neg_ref != w_ref[WIDTH-1]);
    fifo_empty  = (occ_q == '0);
    fifo_full_w = (occ_q == DEPTH_L);
    pop         = rd_en && !fifo_empty;
    push_req    = accept && mismatch;
    // A full FIFO still takes the entry when the head leaves on the same edge.
    push        = push_req && (!fifo_full_w || pop);
    mem_wdata   = {in_func, w_dut, zero_dut, neg_dut};
  end

  // Next-state for the run FSM, counters, sticky flags and FIFO pointers.
  always_comb begin
    state_d           = state_q;
    op_cnt_d          = op_cnt_q;
    mis_cnt_d         = mis_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_func_d  = first_err_func_q;
    first_err_idx_d   = first_err_idx_q;
    overflow_d        = overflow_q;
    consist_err_d     = consist_err_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    occ_d             = occ_q;
    mem_we            = 1'b0;

    if (clear) begin
      state_d           = ST_RUN;
      op_cnt_d          = '0;
      mis_cnt_d         = '0;
      first_err_valid_d = 1'b0;
      first_err_func_d  = '0;
      first_err_idx_d   = '0;
      overflow_d        = 1'b0;
      consist_err_d     = 1'b0;
      wr_ptr_d          = '0;
      rd_ptr_d          = '0;
      occ_d             = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
        2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
        default: occ_d = occ_q;
      endcase
      if (push_req && !push) begin
        overflow_d = 1'b1;
      end

      if (accept) begin
        if (op_cnt_q != '1) begin
          op_cnt_d = op_cnt_q + CNT_W'(1);
        end
        if (inconsist) begin
          consist_err_d = 1'b1;
        end
        if (mismatch) begin
          if (mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
          end
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_func_d  = in_func;
            first_err_idx_d   = op_cnt_q;
`ifdef MON_HALT_ON_ERR_EN
            state_d = ST_HALT;
`endif
          end
        end
      end

      if ((state_q == ST_RUN) && stop) begin
        state_d = ST_HALT;
      end
    end
  end

  // Register all control state; synchronous reset discards FIFO contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      op_cnt_q          <= '0;
      mis_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_func_q  <= '0;
      first_err_idx_q   <= '0;
      overflow_q        <= 1'b0;
      consist_err_q     <= 1'b0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
    end else begin
      state_q           <= state_d;
      op_cnt_q          <= op_cnt_d;
      mis_cnt_q         <= mis_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_func_q  <= first_err_func_d;
      first_err_idx_q   <= first_err_idx_d;
      overflow_q        <= overflow_d;
      consist_err_q     <= consist_err_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      occ_q             <= occ_d;
    end
  end

  // FIFO storage; contents need no reset because rd_data is gated by empty.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign rd_data         = (occ_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign rd_empty        = (occ_q == '0);
  assign fifo_full       = (occ_q == DEPTH_L);
  assign overflow        = overflow_q;
  assign consist_err     = consist_err_q;
  assign op_cnt          = op_cnt_q;
  assign mis_cnt         = mis_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_func  = first_err_func_q;
  assign first_err_idx   = first_err_idx_q;
  assign state           = state_q;

endmodule

// File: doc/alu_result_monitor.md
Name: alu_result_monitor

Overview:
- Synthesizable response-side monitor for the 16-bit structural ALU.
- Receives the operation code plus two ALU result sets per operation: reference (structural) and DUT (synthesized netlist). It checks they match and that the flags are self-consistent.
- Counts operations and mismatches, records the first failure, and buffers mismatching entries in a small FIFO for later read-out.
- Sits opposite the stimulus driver, on the consuming end of the ALU result interface {w, zero, neg}.

Parameters:
- WIDTH, 16, ALU data width.
- FIFO_DEPTH, 8, mismatch FIFO entries (power of two, >= 2).
- CNT_W, 16, width of op and mismatch counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart a run; clears counters, FIFO and first-error record.
- stop  in  1  end the run and go to HALT.
- in_valid  in  1  ALU result sets and in_func are valid this cycle.
- in_func  in  3  ALU function code of this operation.
- w_ref  in  WIDTH  reference result.
- zero_ref, neg_ref  in  1 each  reference flags.
- w_dut  in  WIDTH  DUT result.
- zero_dut, neg_dut  in  1 each  DUT flags.
- rd_en  in  1  pop one FIFO entry.
- rd_data  out  WIDTH+5  {func[2:0], w_dut, zero_dut, neg_dut} of the head entry.
- rd_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- overflow  out  1  sticky: a mismatch was dropped because the FIFO was full.
- consist_err  out  1  sticky: reference flags inconsistent with w_ref.
- op_cnt  out  CNT_W  accepted operations, saturating.
- mis_cnt  out  CNT_W  mismatching operations, saturating.
- first_err_valid  out  1  first mismatch recorded.
- first_err_func  out  3  in_func of the first mismatch.
- first_err_idx  out  CNT_W  op_cnt value at the first mismatch (0-based).
- state  out  2  IDLE=0, RUN=1, HALT=2.

Behaviour:
- Reset, synchronous on rst=1: state=IDLE, all counters 0, FIFO empty (rd_empty=1, fifo_full=0), all sticky flags 0, first_err_* 0, rd_data 0. Applies mid-run too; pending FIFO contents are discarded.
- IDLE: in_valid is ignored. start=1 moves to RUN next cycle.
- RUN:
  - in_valid=1 means accepted: op_cnt increments by 1 on that edge (visible next cycle), saturating at all-ones.
  - Mismatch = (w_ref != w_dut) or (zero_ref != zero_dut) or (neg_ref != neg_dut).
  - On a mismatch:
    - mis_cnt increments, saturating.
    - If first_err_valid=0: first_err_valid=1, and first_err_func/first_err_idx are set from in_func and the pre-increment op_cnt.
    - Entry is pushed to the FIFO. If the FIFO is full and there is no simultaneous pop, the entry is dropped and overflow=1.
  - Consistency: if in_valid and (zero_ref != (w_ref==0) or neg_ref != w_ref[WIDTH-1]), then consist_err=1. This check does not affect mis_cnt.
  - stop=1 moves to HALT. If start and stop are both high, stop wins.
- HALT: in_valid is ignored and counters hold. start=1 moves to RUN and clears counters, FIFO, sticky flags and first_err_*. stop has no effect.
- start while in RUN: restart. Clear everything and stay in RUN; that cycle's in_valid is not counted.
- FIFO:
  - Show-ahead: rd_data always shows the head entry, 0 when empty.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle, full: both occur, no overflow, occupancy unchanged.
  - Push and pop in the same cycle, empty: the pop is ignored and the push occurs.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
  - Pops remain legal in HALT and IDLE.
- Latency: every output updates one clock after the sampling edge. No combinational path from inputs to outputs except rd_data from FIFO storage.

Optional Feature:
- Macro MON_HALT_ON_ERR_EN.
- Defined: on the first mismatch in RUN, the monitor records it exactly as above, pushes it to the FIFO, and moves to HALT on the same edge. Later in_valid is ignored.
- Undefined: RUN continues after mismatches; only stop ends the run.

Test Plan:
- rst=1 for 2 cycles after random activity -> state=0, op_cnt=0, mis_cnt=0, rd_empty=1, all sticky flags 0.
- start, then 10 in_valid with identical ref/dut (w=16'h1234, flags 0/0) -> op_cnt=10, mis_cnt=0, rd_empty=1, consist_err=0.
- RUN; op index 3 has w_dut=16'h00FF vs w_ref=16'h00FE, func=3'd5 -> mis_cnt=1, first_err_func=5, first_err_idx=3, rd_data={3'd5,16'h00FF,0,0}; one rd_en -> rd_empty=1. With MON_HALT_ON_ERR_EN: state=HALT and op_cnt=4 after further inputs.
- 9 consecutive mismatches with no rd_en -> fifo_full=1, overflow=1, mis_cnt=9. A 10th mismatch with rd_en in the same cycle -> overflow unchanged, occupancy stays 8.
- in_valid with w_ref=0, zero_ref=0 -> consist_err=1, mis_cnt unchanged. Then start and stop high together in RUN -> state=HALT, counters held.
- stop, then in_valid pulses in HALT -> op_cnt unchanged. Then start -> state=RUN, all counters and flags cleared.
